// File: rtl/proc_sequencer.sv
// Instruction sequencer for the 16-bit multi-cycle core: a writable program buffer
// that is issued one word at a time over the Run/Done handshake, with a Done watchdog.
module proc_sequencer #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    input  logic          step_mode,
    input  logic          step,
    input  logic          abort,
    output logic [15:0]   DIN,
    output logic          Run,
    input  logic          Done,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          finished,
    output logic          error,
    output logic [15:0]   instr_cnt
);

    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ISSUE,
        WAIT,
        PAUSE,
        HALT,
        ERROR
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [15:0]   mem [DEPTH];
    logic [AW:0]   len_q;
    logic          step_q;
    logic [WW-1:0] wdog;
    logic [AW:0]   pc_inc;
    logic [AW:0]   len_clamped;
    logic          last_instr;
    logic          loadable;

    // pc+1 is compared one bit wider so a full-buffer program still detects its end
    assign pc_inc      = {1'b0, pc} + (AW + 1)'(1);
    assign last_instr  = (pc_inc == len_q);
    assign len_clamped = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
    assign loadable    = (state == IDLE) || (state == HALT) || (state == ERROR);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, HALT, ERROR: begin
                    if (start) begin
                        if (prog_len == '0) begin
                            next_state = HALT;
                        end else if (step_mode) begin
                            next_state = PAUSE;
                        end else begin
                            next_state = PREP;
                        end
                    end
                end
                PREP:  next_state = ISSUE;
                ISSUE: next_state = WAIT;
                WAIT: begin
                    if (Done) begin
                        if (last_instr) begin
                            next_state = HALT;
                        end else if (step_q) begin
                            next_state = PAUSE;
                        end else begin
                            next_state = PREP;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        next_state = ERROR;
                    end
                end
                PAUSE: begin
                    if (step) begin
                        next_state = PREP;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        Run  = (state == ISSUE);
        busy = (state == ISSUE) || (state == WAIT) || (state == PAUSE);
    end

    // An abort freezes pc, count and flags so the host can see where execution stopped
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pc        <= '0;
            len_q     <= '0;
            step_q    <= 1'b0;
            wdog      <= '0;
            finished  <= 1'b0;
            error     <= 1'b0;
            instr_cnt <= '0;
        end else if (!abort) begin
            case (state)
                IDLE, HALT, ERROR: begin
                    if (start) begin
                        pc        <= '0;
                        instr_cnt <= '0;
                        error     <= 1'b0;
                        finished  <= (prog_len == '0);
                        len_q     <= len_clamped;
                        step_q    <= step_mode;
                    end
                end
                ISSUE: wdog <= '0;
                WAIT: begin
                    wdog <= wdog + WW'(1);
                    if (Done) begin
                        pc <= pc + AW'(1);
                        if (instr_cnt != 16'hFFFF) begin
                            instr_cnt <= instr_cnt + 16'd1;
                        end
                        if (last_instr) begin
                            finished <= 1'b1;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // DIN tracks mem[pc] continuously; pc is still during ISSUE/WAIT so the word is stable
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            DIN <= '0;
        end else begin
            DIN <= mem[pc];
        end
    end

    always_ff @(posedge Clock) begin
        if (load_en && loadable) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed self-checking bench for proc_sequencer, driving a small behavioural
// model of the mv/mvt/add/sub core on the Run/Done handshake.
module tb_proc_sequencer;

    localparam int AW      = 5;
    localparam int TIMEOUT = 8;

    logic          Clock;
    logic          Resetn;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic          start;
    logic [AW:0]   prog_len;
    logic          step_mode;
    logic          step;
    logic          abort;
    logic [15:0]   DIN;
    logic          Run;
    logic          Done;
    logic [AW-1:0] pc;
    logic          busy;
    logic          finished;
    logic          error;
    logic [15:0]   instr_cnt;

    int checkCount = 0;
    int passCount  = 0;
    int runCount   = 0;
    int runDouble  = 0;
    logic prevRun  = 1'b0;

    proc_sequencer #(.DEPTH(32), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Resetn(Resetn), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .prog_len(prog_len), .step_mode(step_mode),
        .step(step), .abort(abort), .DIN(DIN), .Run(Run), .Done(Done), .pc(pc),
        .busy(busy), .finished(finished), .error(error), .instr_cnt(instr_cnt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Core model: T0 latches DIN on Run; mv/mvt finish in T1, add/sub in T3.
    logic [15:0] creg [8];
    logic [15:0] ir;
    logic [1:0]  cstep;
    logic        coreStub;
    logic [15:0] operand;

    assign operand = ir[12] ? {7'b0, ir[8:0]} : creg[ir[2:0]];
    assign Done = !coreStub && (((cstep == 2'd1) && (ir[15:14] == 2'b00)) || (cstep == 2'd3));

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cstep <= 2'd0;
            ir    <= 16'h0;
        end else begin
            case (cstep)
                2'd0: if (Run && !coreStub) begin
                    ir    <= DIN;
                    cstep <= 2'd1;
                end
                2'd1: begin
                    if (ir[15:13] == 3'b000) begin
                        creg[ir[11:9]] <= operand;
                        cstep <= 2'd0;
                    end else if (ir[15:13] == 3'b001) begin
                        creg[ir[11:9]] <= {ir[7:0], 8'h00};
                        cstep <= 2'd0;
                    end else begin
                        cstep <= 2'd2;
                    end
                end
                2'd2: cstep <= 2'd3;
                default: begin
                    if (ir[15:13] == 3'b010) creg[ir[11:9]] <= creg[ir[11:9]] + operand;
                    else                     creg[ir[11:9]] <= creg[ir[11:9]] - operand;
                    cstep <= 2'd0;
                end
            endcase
        end
    end

    always @(negedge Clock) begin
        if (Resetn) begin
            if (Run) runCount <= runCount + 1;
            if (Run && prevRun) runDouble <= runDouble + 1;
            prevRun <= Run;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(negedge Clock);
        #1;
    endtask

    task automatic loadWord(input logic [AW-1:0] addr, input logic [15:0] data);
        load_addr = addr;
        load_data = data;
        load_en   = 1'b1;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [AW:0] len, input logic smode);
        prog_len  = len;
        step_mode = smode;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic waitFinish(input string tag, input int bound);
        int n = 0;
        while (!finished && !error && n < bound) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'b0, finished}, 32'd1);
    endtask

    task automatic waitRun(input string tag, input int bound);
        int n = 0;
        while (!Run && n < bound) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'b0, Run}, 32'd1);
    endtask

    task automatic pulseStep;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (8) tick();
    endtask

    int base;
    int waits;

    initial begin
        Resetn = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
        prog_len = '0; step_mode = 1'b0; step = 1'b0; abort = 1'b0; coreStub = 1'b0;
        #3;
        checkOutput("rst_din", DIN, 0);
        checkOutput("rst_run", Run, 0);
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_flags", {finished, error}, 0);
        checkOutput("rst_cnt", instr_cnt, 0);
        tick();
        Resetn = 1'b1;
        tick();

        // mv r0,#5 ; add r0,#3 ; sub r0,#1
        loadWord(5'd0, 16'h1005);
        loadWord(5'd1, 16'h5003);
        loadWord(5'd2, 16'h7001);

        base = runCount;
        applyStimulus(6'd3, 1'b0);
        waitFinish("free_finish", 100);
        checkOutput("free_runs", runCount - base, 3);
        checkOutput("free_r0", creg[0], 7);
        checkOutput("free_cnt", instr_cnt, 3);
        checkOutput("free_pc", pc, 3);
        checkOutput("free_busy_err", {busy, error}, 0);

        base = runCount;
        applyStimulus(6'd3, 1'b1);
        repeat (5) tick();
        checkOutput("step_no_run", runCount - base, 0);
        checkOutput("step_paused", busy, 1);
        for (int k = 1; k <= 3; k++) begin
            pulseStep();
            checkOutput("step_runs", runCount - base, k);
            checkOutput("step_cnt", instr_cnt, k);
        end
        checkOutput("step_finished", finished, 1);
        pulseStep();
        checkOutput("step_extra_runs", runCount - base, 3);
        checkOutput("step_extra_pc", pc, 3);

        coreStub = 1'b1;
        applyStimulus(6'd3, 1'b0);
        waitRun("wdog_run", 10);
        waits = 0;
        for (int n = 0; n < 20 && !error; n++) begin
            tick();
            if (busy && !error) waits++;
        end
        checkOutput("wdog_cycles", waits, TIMEOUT);
        checkOutput("wdog_error", error, 1);
        checkOutput("wdog_pc", pc, 0);
        checkOutput("wdog_run_busy", {Run, busy}, 0);
        coreStub = 1'b0;
        applyStimulus(6'd3, 1'b0);
        waitFinish("wdog_rerun", 100);
        checkOutput("wdog_err_clr", error, 0);
        checkOutput("wdog_r0", creg[0], 7);

        applyStimulus(6'd3, 1'b0);
        for (int n = 0; n < 60 && !(Done && instr_cnt == 16'd1); n++) tick();
        checkOutput("abort_sync", {31'b0, Done}, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_pc", pc, 1);
        checkOutput("abort_cnt", instr_cnt, 1);
        base = runCount;
        repeat (10) tick();
        checkOutput("abort_no_run", runCount - base, 0);
        checkOutput("abort_fin", finished, 0);
        loadWord(5'd3, 16'h1009);
        applyStimulus(6'd4, 1'b0);
        waitFinish("abort_load_run", 100);
        checkOutput("abort_load_r0", creg[0], 9);

        applyStimulus(6'd4, 1'b0);
        waitRun("wload_run", 10);
        tick();
        loadWord(5'd3, 16'h1001);
        waitFinish("wload_finish", 100);
        checkOutput("wload_r0", creg[0], 9);
        checkOutput("wload_cnt", instr_cnt, 4);

        for (int a = 4; a < 32; a++) loadWord(a[AW-1:0], 16'h5001);
        applyStimulus(6'd40, 1'b0);
        waitFinish("clamp_finish", 400);
        checkOutput("clamp_cnt", instr_cnt, 32);
        checkOutput("clamp_pc", pc, 0);
        checkOutput("clamp_r0", creg[0], 37);

        base = runCount;
        applyStimulus(6'd0, 1'b0);
        checkOutput("zero_fin", finished, 1);
        checkOutput("zero_cnt", instr_cnt, 0);
        repeat (3) tick();
        checkOutput("zero_no_run", runCount - base, 0);
        checkOutput("zero_busy", busy, 0);

        applyStimulus(6'd3, 1'b0);
        for (int n = 0; n < 60 && !(Run && instr_cnt == 16'd2); n++) tick();
        checkOutput("rstw_sync", {31'b0, Run}, 1);
        tick();
        checkOutput("rstw_pre_pc", pc, 2);
        #2;
        Resetn = 1'b0;
        #1;
        checkOutput("rstw_din", DIN, 0);
        checkOutput("rstw_run_busy", {Run, busy}, 0);
        checkOutput("rstw_pc", pc, 0);
        checkOutput("rstw_flags", {finished, error}, 0);
        checkOutput("rstw_cnt", instr_cnt, 0);
        tick();
        Resetn = 1'b1;
        tick();
        applyStimulus(6'd4, 1'b0);
        waitFinish("rstw_rerun", 100);
        checkOutput("rstw_r0", creg[0], 9);
        checkOutput("rstw_cnt4", instr_cnt, 4);

        checkOutput("run_back_to_back", runDouble, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
- Instruction sequencer that feeds the 16-bit multi-cycle processor core (mv/mvt/add/sub, Run/Done handshake).
- Holds a small writable program buffer and issues one instruction at a time: drives DIN, pulses Run, waits for Done, then advances the PC.
- Supports free-run and single-step modes, a Done watchdog, and completion and error status for the host/testbench.

Parameters:
DEPTH, 32, program buffer depth in 16-bit words (power of 2).
AW, 5, address width, log2(DEPTH).
TIMEOUT, 8, max cycles in WAIT without Done before ERROR (core worst case is 3).

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
load_en  in  1  write program word (honoured only in IDLE, HALT or ERROR)
load_addr  in  AW  program write address
load_data  in  16  program word
start  in  1  begin execution at address 0
prog_len  in  AW+1  number of instructions, sampled on start
step_mode  in  1  1 = pause before each issue, sampled on start
step  in  1  advance one instruction while PAUSE
abort  in  1  force return to IDLE
DIN  out  16  instruction word to core
Run  out  1  issue strobe to core
Done  in  1  core completion, combinational from core
pc  out  AW  address of current/next instruction
busy  out  1  state is ISSUE, WAIT or PAUSE
finished  out  1  sticky, set on entering HALT
error  out  1  sticky, set on watchdog expiry
instr_cnt  out  16  instructions completed since start, saturating at 16'hFFFF

Behaviour:
Reset (async, Resetn=0):
- State IDLE; pc=0; len_q=0; step_q=0; DIN=0; Run=0; busy=0; finished=0; error=0; instr_cnt=0; wdog=0.
- Buffer contents are not reset.

Buffer write:
- Synchronous; mem[load_addr] <= load_data when load_en=1 and state is IDLE, HALT or ERROR.
- Write ignored in all other states.

DIN:
- Registered; always equals mem[pc] one cycle after pc changes.
- Held stable through ISSUE and WAIT (the core loads IR on every cycle it spends in T0).

States:
- IDLE: on start -> pc=0, instr_cnt=0, finished=0, error=0, len_q=prog_len, step_q=step_mode.
  - If prog_len==0 -> HALT.
  - Else if step_q -> PAUSE, else PREP.
- PREP: one cycle so DIN=mem[pc] is valid before Run. -> ISSUE.
- ISSUE: Run=1 for exactly one cycle; wdog=0. -> WAIT.
- WAIT: Run=0; wdog increments each cycle.
  - Done=1 -> pc+1, instr_cnt+1 (saturating).
    - If pc+1==len_q -> HALT.
    - Else if step_q -> PAUSE, else PREP.
  - Done=0 and wdog==TIMEOUT-1 -> ERROR.
- PAUSE: wait for step=1 -> PREP. step in other states ignored.
- HALT: finished=1. start restarts as from IDLE.
- ERROR: error=1; pc holds the faulting address. start restarts as from IDLE.
- abort=1 in any state -> IDLE next cycle, Run=0; pc, instr_cnt and flags hold.
  - abort has priority over start and Done in the same cycle.
  - Abort mid-instruction leaves the core to finish on its own; the block does not observe it.

Issue timing:
- Minimum period per instruction is PREP + ISSUE + the core's 1–3 WAIT cycles.
- After Done the core is in T0 next cycle, so the next issue is always legal.

Run protocol:
- Never asserted outside ISSUE.
- Never asserted on two consecutive cycles.

Boundaries:
- start while busy is ignored.
- Done while not in WAIT is ignored.
- prog_len > DEPTH is clamped to DEPTH.
- pc wraps mod DEPTH only when len_q==DEPTH (at which point HALT is reached anyway).

Test Plan:
- Load {mv r0,#5; add r0,#3; sub r0,#1}, prog_len=3, start with step_mode=0 -> three single-cycle Run pulses. Core r0=7, finished=1, instr_cnt=3, pc=3, busy=0, error=0.
- Same program with step_mode=1 -> stops in PAUSE before each instruction, no Run pulses until step. Three steps -> finished=1; a fourth step has no effect.
- Done held low (core stubbed) -> ERROR exactly TIMEOUT cycles after the ISSUE cycle. error=1, pc=0, Run=0, busy=0. Next start clears error and reruns.
- abort asserted in the same cycle as Done during the second instruction -> IDLE next cycle. pc=1, instr_cnt=1, no further Run. load_en is accepted afterwards.
- load_en asserted during WAIT -> buffer unchanged (readback via a rerun matches original results). prog_len=0 start -> HALT immediately with no Run pulse and instr_cnt=0.
- Resetn dropped asynchronously mid-WAIT -> all outputs at reset values before the next clock edge; buffer contents retained.
